// File: rtl/seq_arb_if.sv
// seq_arb_if: requester/status bundle for seq_arb_detector.
interface seq_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] bit_in;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] gnt_id;
  logic det_pulse;
  logic done;
  logic aborted;
  logic [CNT_W-1:0] frame_matches;
  modport master (
    output req, bit_in,
    input gnt, gnt_id, det_pulse, done, aborted, frame_matches
  );
  modport slave (
    input req, bit_in,
    output gnt, gnt_id, det_pulse, done, aborted, frame_matches
  );
endinterface

// File: rtl/seq_arb_detector.sv
// seq_arb_detector: round-robin frame scheduler sharing one non-overlapping "1011" detector.
// Define SEQ_ARB_ABORT_EN to end a frame early when the granted lane drops req.
module seq_arb_detector #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  seq_arb_if.slave s
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(FRAME_LEN);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_t;
  state_t state, state_nx;
  det_t ds, ds_nx;
  logic [IW-1:0] last_gnt, win, idx, gnt_id;
  logic [BW-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt, cnt_nx, frame_matches;
  logic det_pulse, b, abort, sample, match, fin;
  assign b = s.bit_in[gnt_id];
`ifdef SEQ_ARB_ABORT_EN
  logic ab_r;
  assign abort = state == GRANT && !s.req[gnt_id];
  assign s.aborted = ab_r && state == GAP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ab_r <= 1'b0;
    else if (state == GRANT) ab_r <= abort;
  end
`else
  assign abort = 1'b0;
  assign s.aborted = 1'b0;
`endif
  assign sample = state == GRANT && !abort;
  assign fin = sample && bit_cnt == BW'(FRAME_LEN - 1);
  assign match = sample && ds == S101 && b;
  assign cnt_nx = match && !(&cnt) ? cnt + 1'b1 : cnt;
  // Non-overlapping: a match returns to S0 rather than a partial-match state.
  always_comb begin
    ds_nx = ds;
    case (ds)
      S0: ds_nx = b ? S1 : S0;
      S1: ds_nx = b ? S1 : S10;
      S10: ds_nx = b ? S101 : S0;
      default: ds_nx = b ? S0 : S10;
    endcase
  end
  // Scan downwards so the nearest requester after last_gnt overwrites the rest.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_gnt) + i) % NUM_REQ);
      if (s.req[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |s.req ? GRANT : IDLE;
      GRANT: state_nx = abort || fin ? GAP : GRANT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id <= '0;
      last_gnt <= IW'(NUM_REQ - 1);
      ds <= S0;
      bit_cnt <= '0;
      cnt <= '0;
      frame_matches <= '0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= match;
      if (state == IDLE && |s.req) begin
        gnt_id <= win;
        last_gnt <= win;
        ds <= S0;
        bit_cnt <= '0;
        cnt <= '0;
      end
      if (sample) begin
        ds <= ds_nx;
        bit_cnt <= bit_cnt + 1'b1;
        cnt <= cnt_nx;
      end
      if (state == GRANT && (abort || fin)) frame_matches <= cnt_nx;
    end
  end
  assign s.gnt = state == GRANT ? NUM_REQ'(1) << gnt_id : '0;
  assign s.gnt_id = gnt_id;
  assign s.det_pulse = det_pulse;
  assign s.done = state == GAP;
  assign s.frame_matches = frame_matches;
endmodule

// File: tb/tb_seq_arb_detector.sv
// tb_seq_arb_detector: directed and random frames checked against a pattern-scan model.
module tb_seq_arb_detector;
  localparam int NR = 4;
  localparam int FL = 16;
  localparam int CW = 2;
  localparam int SAT = 3;
`ifdef SEQ_ARB_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int last = NR - 1;
  seq_arb_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();
  seq_arb_detector #(.NUM_REQ(NR), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int l);
    for (int i = 1; i <= NR; i++)
      if (r[(l + i) % NR]) return (l + i) % NR;
    return 0;
  endfunction

  task automatic idle_cycle();
    bus.req = '0;
    bus.bit_in = NR'($urandom);
    @(posedge clk); @(negedge clk);
    check("idle_gnt", 32'(bus.gnt), 0);
    check("idle_done", 32'(bus.done), 0);
  endtask

  // Bits are given first-bit-first (MSB of d is the first serial bit).
  task automatic frame(input logic [NR-1:0] r, input logic [FL-1:0] d, input int drop);
    int w, lim, cnt, i, em;
    logic [FL-1:0] pul;
    logic [NR-1:0] nr;
    w = pick(r, last);
    lim = (ABORT && drop >= 0) ? drop : FL;
    pul = '0;
    cnt = 0;
    i = 0;
    while (i + 3 < lim) begin
      if ({d[FL-1-i], d[FL-2-i], d[FL-3-i], d[FL-4-i]} == 4'b1011) begin
        pul[i+3] = 1'b1;
        cnt++;
        i += 4;
      end else i++;
    end
    em = cnt > SAT ? SAT : cnt;
    bus.req = r;
    bus.bit_in = NR'($urandom);
    @(posedge clk); @(negedge clk);
    check("gnt", 32'(bus.gnt), 32'(1) << w);
    check("gnt_id", 32'(bus.gnt_id), w);
    for (int k = 0; k < FL; k++) begin
      bus.bit_in = NR'($urandom);
      bus.bit_in[w] = d[FL-1-k];
      nr = NR'($urandom);
      nr[w] = !(drop >= 0 && k >= drop);
      bus.req = nr;
      @(posedge clk); @(negedge clk);
      if (ABORT && k == drop) begin
        check("abort_det", 32'(bus.det_pulse), 0);
        check("abort_done", 32'(bus.done), 1);
        check("abort_flag", 32'(bus.aborted), 1);
        check("abort_matches", 32'(bus.frame_matches), em);
        break;
      end
      check("det_pulse", 32'(bus.det_pulse), 32'(pul[k]));
      if (k < FL - 1) check("gnt_hold", 32'(bus.gnt), 32'(1) << w);
      else begin
        check("done", 32'(bus.done), 1);
        check("gnt_gap", 32'(bus.gnt), 0);
        check("aborted", 32'(bus.aborted), 0);
        check("frame_matches", 32'(bus.frame_matches), em);
      end
    end
    last = w;
    @(posedge clk); @(negedge clk);
    check("done_end", 32'(bus.done), 0);
    check("gnt_end", 32'(bus.gnt), 0);
  endtask

  initial begin
    logic [6:0] seq;
    logic [NR-1:0] r;
    bus.req = '0;
    bus.bit_in = '0;
    @(negedge clk); @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_gnt_id", 32'(bus.gnt_id), 0);
    check("rst_det", 32'(bus.det_pulse), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_aborted", 32'(bus.aborted), 0);
    check("rst_matches", 32'(bus.frame_matches), 0);
    rst_n = 1'b1;
    idle_cycle();
    frame(4'b0001, 16'b1011_1011_0000_0000, -1);
    frame(4'b0001, 16'b1011_0110_0000_0000, -1);
    frame(4'b0010, 16'b0000_0000_0000_0101, -1);
    frame(4'b0100, 16'b1011_0000_0000_0000, -1);
    frame(4'b0001, 16'b1011_1011_1011_1011, -1);
    frame(4'b0001, 16'b1011_0000_0000_0000, 5);
    // Reset in the middle of a lane-2 frame, just as a match pulse is showing.
    seq = 7'b0001011;
    bus.req = 4'b0100;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      bus.bit_in = NR'($urandom);
      bus.bit_in[2] = seq[6-k];
      @(posedge clk); @(negedge clk);
    end
    check("pre_rst_det", 32'(bus.det_pulse), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_det", 32'(bus.det_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last = NR - 1;
    for (int n = 0; n < 5; n++) frame(4'b1111, FL'($urandom), -1);
    for (int n = 0; n < 24; n++) begin
      r = NR'($urandom);
      if (r == '0) idle_cycle();
      else frame(r, FL'($urandom), $urandom_range(0, 3) == 0 ? int'($urandom_range(0, FL - 1)) : -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_arb_detector.md
# seq_arb_detector

Round-robin scheduler that shares a single non-overlapping Mealy "1011" serial pattern detector among `NUM_REQ` requesters. Each grant gives one requester a fixed-length frame of serial bits. The detector context is cleared at every frame start, and matches are counted per frame. The block sits between the per-lane serial sources and the status/interrupt logic that consumes per-frame match counts.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `FRAME_LEN`, default 16: bits per granted frame, 4..256.
- `CNT_W`, default 8: width of the match counter, saturating.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  `NUM_REQ`  per-requester frame request, level.
- `bit_in`  in  `NUM_REQ`  per-requester serial data; only the granted lane is sampled.
- `gnt`  out  `NUM_REQ`  one-hot grant; reset 0.
- `gnt_id`  out  `$clog2(NUM_REQ)`  index of the current/last grant; reset 0.
- `det_pulse`  out  1  one-cycle pulse per detected 1011; reset 0.
- `done`  out  1  one-cycle end-of-frame pulse; reset 0.
- `aborted`  out  1  qualifies `done`: frame ended early; reset 0.
- `frame_matches`  out  `CNT_W`  match count of the last frame, held until next `done`; reset 0.

## Operation
- Arbiter FSM states:
  - **IDLE**: if any `req` is set, pick a winner and go to GRANT. Otherwise stay in IDLE.
  - **GRANT**: sample `bit_in[gnt_id]` each cycle while `bit_cnt` runs 0..FRAME_LEN-1. After the last sample, go to GAP.
  - **GAP**: drive `gnt`=0 and `done`=1 (one cycle), update `frame_matches`, then return to IDLE.
- Round robin:
  - Search starts at `(last_gnt+1) mod NUM_REQ`; the first set `req` wins.
  - After reset, `last_gnt` = NUM_REQ-1, so requester 0 has top priority.
- Detector states, reset to S0 on every IDLE→GRANT transition:
  - S0: 1→S1, 0→S0.
  - S1: 1→S1, 0→S10.
  - S10: 1→S101, 0→S0.
  - S101: 1→S0 and match; 0→S10.
  - This is non-overlapping: after a match the detector restarts at S0.
- On a match, increment the count, saturating at 2^CNT_W-1 (no wrap), and register `det_pulse`.
- Without the configuration macro, `req` of the granted lane is ignored during GRANT. The requester must supply all FRAME_LEN bits.
- A `det_pulse` caused by the final bit of a frame is still counted in that frame's `frame_matches`.
- Asserting `rst_n` mid-frame:
  - Returns all state to reset immediately.
  - Drops the frame with no `done`.
  - Resets the round-robin pointer.

## Timing
- IDLE sees `req` at edge N → `gnt`/`gnt_id` valid after edge N.
- The first bit is sampled at edge N+1; the last bit at edge N+FRAME_LEN.
- `det_pulse` is high in the cycle after the edge that sampled the completing '1'. It is registered, never combinational.
- `done`, `aborted` and the new `frame_matches` are valid in the cycle after the last sample edge. `gnt` is low in that cycle.
- Back-to-back frames: FRAME_LEN+2 cycles per frame (GRANT, GAP, IDLE).
- `req` transitions during GRANT or GAP do not affect the current frame; arbitration uses only `req` in IDLE.

## Configuration
- `SEQ_ARB_ABORT_EN` defined:
  - If `req[gnt_id]` is sampled low during GRANT, that bit is not processed and the FSM goes to GAP.
  - `done`=1 and `aborted`=1, and `frame_matches` holds the partial count.
- `SEQ_ARB_ABORT_EN` undefined:
  - Dropping `req` during a frame is ignored.
  - `aborted` is tied to 0.

## Test plan
- Single requester 0, FRAME_LEN=16, bits 1011_1011_0000_0000 → `det_pulse` after sample edges 4 and 8, `done` with `frame_matches`=2, `gnt_id`=0.
- Non-overlap: bits 1011011 followed by zeros → exactly 1 match (an overlapping detector would give 2), `frame_matches`=1.
- All four `req` held high continuously → grants 0,1,2,3,0 in order, each frame FRAME_LEN+2 cycles apart, and `gnt` always one-hot.
- Detector reset per frame: lane 1 ends its frame in state S101, then lane 2 sends '1' as its first bit → no `det_pulse` on lane 2's first bit.
- Saturation, with CNT_W=2 and all-1011 frame data → `frame_matches`=3 (not 0).
- `rst_n` low mid-frame at bit 7 → `gnt`, `done` and `det_pulse` go to 0 immediately, and the next grant goes to requester 0.
- With `SEQ_ARB_ABORT_EN`: drop `req[0]` at bit 5 → `done`=1, `aborted`=1, `frame_matches`=1 given bits 1011.
